au_cmd_driver: RTL

AU_CMD_DRIVER -- requirements
Module: au_cmd_driver

---
 rtl/au_cmd_driver_pkg.sv | 24 ++
 rtl/au_cmd_driver_au.sv | 59 +++++
 rtl/au_cmd_driver.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/au_cmd_driver_pkg.sv
// rtl/au_cmd_driver_pkg.sv - shared op encodings, FSM state type and queue entry layout
package au_cmd_driver_pkg;

    localparam int TAG_W = 2;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_CMP = 2'b10;
    localparam logic [1:0] OP_ABS = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [7:0]       a;
        logic [7:0]       b;
        logic [1:0]       op;
        logic [TAG_W-1:0] tag;
    } cmd_entry_t;

endpackage

// File: rtl/au_cmd_driver_au.sv
// rtl/au_cmd_driver_au.sv - combinational 8-bit signed arithmetic unit with flags
module au_cmd_driver_au
    import au_cmd_driver_pkg::*;
(
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic [1:0] i_op,
    output logic [7:0] o_result,
    output logic       o_overflow,
    output logic       o_zero,
    output logic       o_negative
);

    logic [8:0] w_sum;
    logic [8:0] w_diff;
    logic [8:0] w_abs;
    logic [7:0] w_result;
    logic       w_overflow;

    // Nine-bit sign-extended sum/difference so overflow and |a-b| are exact
    always_comb begin
        w_sum      = {i_a[7], i_a} + {i_b[7], i_b};
        w_diff     = {i_a[7], i_a} - {i_b[7], i_b};
        w_abs      = w_diff[8] ? (9'd0 - w_diff) : w_diff;
        w_result   = 8'd0;
        w_overflow = 1'b0;
        case (i_op)
            OP_ADD: begin
                w_result   = w_sum[7:0];
                w_overflow = w_sum[8] ^ w_sum[7];
            end
            OP_SUB: begin
                w_result   = w_diff[7:0];
                w_overflow = w_diff[8] ^ w_diff[7];
            end
            OP_CMP: begin
                // Three-way compare: -1 below, 0 equal, +1 above
                if ($signed(i_a) < $signed(i_b)) begin
                    w_result = 8'hFF;
                end else if (i_a == i_b) begin
                    w_result = 8'h00;
                end else begin
                    w_result = 8'h01;
                end
            end
            default: begin
                // |a-b| is non-negative; anything above 127 does not fit
                w_result   = w_abs[7:0];
                w_overflow = w_abs[8] | w_abs[7];
            end
        endcase
    end

    assign o_result   = w_result;
    assign o_overflow = w_overflow;
    assign o_zero     = (w_result == 8'd0);
    assign o_negative = w_result[7];

endmodule

// File: rtl/au_cmd_driver.sv
// rtl/au_cmd_driver.sv - command FIFO and sequencer feeding one arithmetic unit
module au_cmd_driver
    import au_cmd_driver_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    input  logic [1:0]       cmd_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_result,
    output logic             rsp_overflow,
    output logic             rsp_zero,
    output logic             rsp_negative,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [7:0]       ovf_count,
    output logic             busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    cmd_entry_t       r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [TAG_W-1:0] r_tag;

    state_t           r_state;
    logic [7:0]       r_op_a;
    logic [7:0]       r_op_b;
    logic [1:0]       r_op_code;
    logic [TAG_W-1:0] r_op_tag;

    logic             r_rsp_valid;
    logic [7:0]       r_rsp_result;
    logic             r_rsp_overflow;
    logic             r_rsp_zero;
    logic             r_rsp_negative;
    logic [TAG_W-1:0] r_rsp_tag;
    logic [7:0]       r_ovf_count;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    cmd_entry_t       w_head;
    logic [7:0]       w_au_result;
    logic             w_au_overflow;
    logic             w_au_zero;
    logic             w_au_negative;

    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = cmd_valid && !w_full;
    // The head leaves the FIFO whenever the sequencer is free to take it
    assign w_pop   = !w_empty && ((r_state == ST_IDLE) || ((r_state == ST_RESP) && rsp_ready));
    assign w_head  = r_mem[r_rd_ptr];

    // Entry storage; contents are don't-care while the slot is empty, so no reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{a: cmd_a, b: cmd_b, op: cmd_op, tag: r_tag};
        end
    end

    // FIFO pointers, occupancy and the sequence tag given to each accepted command
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_tag    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_tag    <= r_tag + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    au_cmd_driver_au u_au (
        .i_a        (r_op_a),
        .i_b        (r_op_b),
        .i_op       (r_op_code),
        .o_result   (w_au_result),
        .o_overflow (w_au_overflow),
        .o_zero     (w_au_zero),
        .o_negative (w_au_negative)
    );

    // Sequencer: load operands, capture the unit's outputs, hold until consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_op_a         <= '0;
            r_op_b         <= '0;
            r_op_code      <= '0;
            r_op_tag       <= '0;
            r_rsp_valid    <= 1'b0;
            r_rsp_result   <= '0;
            r_rsp_overflow <= 1'b0;
            r_rsp_zero     <= 1'b0;
            r_rsp_negative <= 1'b0;
            r_rsp_tag      <= '0;
            r_ovf_count    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_op_a    <= w_head.a;
                        r_op_b    <= w_head.b;
                        r_op_code <= w_head.op;
                        r_op_tag  <= w_head.tag;
                        r_state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_rsp_result   <= w_au_result;
                    r_rsp_overflow <= w_au_overflow;
                    r_rsp_zero     <= w_au_zero;
                    r_rsp_negative <= w_au_negative;
                    r_rsp_tag      <= r_op_tag;
                    r_rsp_valid    <= 1'b1;
                    if (w_au_overflow && (r_ovf_count != 8'hFF)) begin
                        r_ovf_count <= r_ovf_count + 8'd1;
                    end
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        if (w_pop) begin
                            r_op_a    <= w_head.a;
                            r_op_b    <= w_head.b;
                            r_op_code <= w_head.op;
                            r_op_tag  <= w_head.tag;
                            r_state   <= ST_EXEC;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready    = !w_full;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_result   = r_rsp_result;
    assign rsp_overflow = r_rsp_overflow;
    assign rsp_zero     = r_rsp_zero;
    assign rsp_negative = r_rsp_negative;
    assign rsp_tag      = r_rsp_tag;
    assign ovf_count    = r_ovf_count;
    assign busy         = !w_empty || (r_state != ST_IDLE);

endmodule
